// File: rtl/seg_scan_display_if.sv
// Load-side bundle for seg_scan_display.
// Master drives the value and strobe; slave reports busy.
interface seg_scan_display_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic              hex_mode;
  logic              busy;

  modport master (
    output din,
    output din_vld,
    output hex_mode,
    input  busy
  );

  modport slave (
    input  din,
    input  din_vld,
    input  hex_mode,
    output busy
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: hex or double-dabble BCD conversion,
// leading-zero blanking, overflow dashes, active-low scan outputs.
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 16,
  parameter int SCAN_CYC = 50_000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_display_if.slave bus,
  input  logic              i_blank_lz,
  output logic [DIGITS-1:0] o_cs,
  output logic [7:0]        o_dx
);

  localparam int NW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_val;
  logic              r_hex;
  logic [NW-1:0]     r_bcd;
  logic              r_ovf_acc;
  logic [CW-1:0]     r_cnt;
  logic [NW-1:0]     r_dig;
  logic              r_ovf;
  logic [SW-1:0]     r_scan;
  logic [IW-1:0]     r_idx;

  logic [NW-1:0]     w_adj;
  logic [NW-1:0]     w_hex;
  logic [7:0]        w_code [DIGITS];
  logic              w_tick;
  logic [IW-1:0]     w_nidx;

  assign bus.busy = (r_state != S_IDLE);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                             r_bcd[4*g +: 4] + 4'd3 :
                             r_bcd[4*g +: 4];
  end

  // Hex digits past the input width read as zero.
  for (genvar b = 0; b < NW; b++) begin : g_hex
    if (b < DATA_W) begin : g_in
      assign w_hex[b] = r_val[b];
    end else begin : g_pad
      assign w_hex[b] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_val     <= '0;
      r_hex     <= 1'b0;
      r_bcd     <= '0;
      r_ovf_acc <= 1'b0;
      r_cnt     <= '0;
      r_dig     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.din_vld) begin
            r_val <= bus.din;
            r_hex <= bus.hex_mode;
            if (bus.hex_mode) begin
              r_state <= S_COMMIT;
            end else begin
              r_bcd     <= '0;
              r_ovf_acc <= 1'b0;
              r_cnt     <= CW'(DATA_W);
              r_state   <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[NW-2:0], r_val[DATA_W-1]};
          r_val <= {r_val[DATA_W-2:0], 1'b0};
          if (w_adj[NW-1]) r_ovf_acc <= 1'b1;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_dig   <= r_hex ? w_hex : r_bcd;
          r_ovf   <= r_hex ? 1'b0 : r_ovf_acc;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [7:0] f_glyph(input logic [3:0] d);
    case (d)
      4'h0: f_glyph = 8'hC0;
      4'h1: f_glyph = 8'hF9;
      4'h2: f_glyph = 8'hA4;
      4'h3: f_glyph = 8'hB0;
      4'h4: f_glyph = 8'h99;
      4'h5: f_glyph = 8'h92;
      4'h6: f_glyph = 8'h82;
      4'h7: f_glyph = 8'hF8;
      4'h8: f_glyph = 8'h80;
      4'h9: f_glyph = 8'h90;
      4'hA: f_glyph = 8'h88;
      4'hB: f_glyph = 8'h83;
      4'hC: f_glyph = 8'hC6;
      4'hD: f_glyph = 8'hA1;
      4'hE: f_glyph = 8'h86;
      default: f_glyph = 8'h8E;
    endcase
  endfunction

  // Walk from the top digit down, tracking "this and all above are zero".
  always_comb begin : c_code
    logic v_z;
    v_z = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_z = v_z & (r_dig[4*i +: 4] == 4'd0);
      if (r_ovf)
        w_code[i] = 8'hBF;
      else if (i_blank_lz && (i != 0) && v_z)
        w_code[i] = 8'hFF;
      else
        w_code[i] = f_glyph(r_dig[4*i +: 4]);
    end
  end

  assign w_tick = (r_scan == SW'(SCAN_CYC - 1));
  assign w_nidx = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= IW'(DIGITS - 1);
      o_cs   <= '1;
      o_dx   <= 8'hFF;
    end else begin
      r_scan <= w_tick ? '0 : r_scan + SW'(1);
      if (w_tick) begin
        r_idx <= w_nidx;
        o_cs  <= ~(DIGITS'(1) << w_nidx);
        o_dx  <= w_code[w_nidx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: random and directed loads
// checked against an arithmetic model of the displayed digits.
module tb_seg_scan_display;
  localparam int DIGITS   = 4;
  localparam int DATA_W   = 16;
  localparam int SCAN_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blank_lz = 1'b0;
  logic [3:0] cs;
  logic [7:0] dx;

  seg_scan_display_if #(.DATA_W(DATA_W)) bus ();

  seg_scan_display #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_CYC(SCAN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .i_blank_lz(blank_lz), .o_cs(cs), .o_dx(dx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q [$];
  logic [7:0] glyph [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int unsigned cur_val = 0;
  bit          cur_hex = 1'b0;

  function automatic logic [7:0] exp_code(int unsigned v, bit hex,
                                          bit blank, int i);
    int unsigned d [DIGITS];
    int unsigned t;
    bit z;
    t = v;
    if (!hex && v >= 10 ** DIGITS) return 8'hBF;
    for (int j = 0; j < DIGITS; j++) begin
      d[j] = hex ? ((v >> (4 * j)) & 15) : (t % 10);
      t = t / 10;
    end
    if (blank && i >= 1) begin
      z = 1'b1;
      for (int j = i; j < DIGITS; j++) if (d[j] != 0) z = 1'b0;
      if (z) return 8'hFF;
    end
    return glyph[d[i]];
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic [3:0]  prev;
    logic [11:0] e;
    prev = '1;
    forever begin
      @(negedge clk);
      if (cs !== prev && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({cs, dx} !== e) begin
          errors++;
          $display("FAIL scan cs=%b dx=%h want cs=%b dx=%h",
                   cs, dx, e[11:8], e[7:0]);
        end
      end
      prev = cs;
    end
  end

  task automatic push_all();
    logic [3:0] c;
    for (int i = 0; i < DIGITS; i++) begin
      c = ~(4'b0001 << i);
      exp_q.push_back({c, exp_code(cur_val, cur_hex, blank_lz, i)});
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic align();
    logic [3:0] last;
    last = cs;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cs == 4'b0111 && last != 4'b0111) begin
        @(posedge clk);
        return;
      end
      last = cs;
    end
    check("align_timeout", 0, 1);
  endtask

  task automatic show();
    align();
    push_all();
    drain();
  endtask

  task automatic load(input logic [15:0] v, input bit hex, output int n);
    @(negedge clk);
    bus.din      = v;
    bus.hex_mode = hex;
    bus.din_vld  = 1'b1;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.din_vld = 1'b0;
      if (bus.busy) n++;
      else break;
    end
    cur_val = v;
    cur_hex = hex;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic [15:0] v;
    bit h;
    bus.din = '0;
    bus.din_vld = 1'b0;
    bus.hex_mode = 1'b0;
    blank_lz = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cs", int'(cs), 4'hF);
    check("rst_dx", int'(dx), 8'hFF);
    rst_n = 1'b1;
    push_all();
    drain();
    blank_lz = 1'b0;
    push_all();
    drain();

    load(16'd1234, 1'b0, n);
    check("busy_dec", n, 17);
    show();
    load(16'hBEEF, 1'b1, n);
    check("busy_hex", n, 1);
    show();
    load(16'd9999, 1'b0, n);
    show();
    load(16'd12345, 1'b0, n);
    show();
    blank_lz = 1'b1;
    load(16'd42, 1'b0, n);
    show();

    blank_lz = 1'b0;
    @(negedge clk);
    bus.din = 16'd1234;
    bus.hex_mode = 1'b0;
    bus.din_vld = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.din = 16'd7;
      bus.din_vld = (k == 5 || k == 17);
      if (bus.busy) n++;
      else break;
    end
    check("busy_drop", n, 17);
    cur_val = 1234;
    cur_hex = 1'b0;
    show();

    blank_lz = 1'b1;
    @(negedge clk);
    bus.din = 16'd1234;
    bus.din_vld = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.din = 16'd7;
      bus.din_vld = (k == 17 || k == 18);
      if (bus.busy) n++;
      else break;
    end
    check("busy_first", n, 17);
    @(negedge clk);
    bus.din_vld = 1'b0;
    check("idle_accept", int'(bus.busy), 1);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    check("busy_7", n, 17);
    cur_val = 7;
    show();

    @(negedge clk);
    bus.din = 16'd5678;
    bus.din_vld = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.din_vld = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_cs", int'(cs), 4'hF);
    check("abort_dx", int'(dx), 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    cur_val = 0;
    cur_hex = 1'b0;
    push_all();
    drain();

    for (int t = 0; t < 12; t++) begin
      h = 1'($urandom_range(0, 1));
      if (h || $urandom_range(0, 3) == 0) v = 16'($urandom);
      else v = 16'($urandom_range(0, 9999));
      blank_lz = 1'($urandom_range(0, 1));
      load(v, h, n);
      check("busy_rand", n, h ? 1 : 17);
      show();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
